lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit between the ex_mem pipeline register and the data RAM bus; drives the memory stage's ram_data_i input.
- Turns a load/store request into a req/gnt/rvalid bus transaction, with byte enables and store-data lane replication.
- Aligns and sign/zero-extends load data and stalls the pipeline until the access completes.
- Flags misaligned and illegal-width accesses instead of issuing them.

Parameters:
- ADDR_W, 32, byte-address width of addr_i and bus_addr_o.
- DATA_W, 32, data width; fixed at 32 for RV32I, and other values are unsupported.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_re_i  in  1  load request from ex_mem.
- mem_we_i  in  1  store request from ex_mem; mutually exclusive with mem_re_i.
- funct3_i  in  3  RV32I width/sign code of the load or store.
- addr_i  in  ADDR_W  effective byte address.
- wdata_i  in  DATA_W  rs2 store data, right-aligned.
- flush_i  in  1  kills the request presented in IDLE; has no effect once issued.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  1 = write, 0 = read.
- bus_addr_o  out  ADDR_W  word-aligned address, low 2 bits forced to 0.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  DATA_W  lane-replicated store data.
- bus_gnt_i  in  1  slave accepted the request.
- bus_rvalid_i  in  1  read data valid.
- bus_rdata_i  in  DATA_W  raw read word.
- ram_data_o  out  DATA_W  formatted load result to the memory stage.
- stall_o  out  1  freeze the upstream pipeline.
- err_o  out  1  misaligned or illegal funct3; combinational, IDLE only.

Behaviour:
- Reset: asynchronous on rst_n low. State returns to IDLE immediately.
  - All registered outputs clear to 0: bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, ram_data_o.
  - stall_o and err_o are therefore 0.
  - Reset mid-transaction abandons it; the bus slave shares rst_n.
- Access = (mem_re_i | mem_we_i) & ~flush_i.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
- FSM states IDLE, REQ, WAIT, DONE.
- IDLE:
  - If access is legal and aligned: latch address, byte enables, write data, funct3 and we into the bus registers; set bus_req_o = 1; go to REQ.
  - If access is illegal or misaligned: err_o = 1, no bus activity, stay in IDLE.
- REQ: hold bus_req_o and all bus fields stable until bus_gnt_i.
  - On gnt with a write: drop req, go to DONE.
  - On gnt with a read: drop req, go to WAIT.
- WAIT: on bus_rvalid_i, register the formatted load into ram_data_o and go to DONE.
  - rvalid in the same cycle as gnt is a protocol violation and is ignored.
- DONE: one cycle, then IDLE. ram_data_o holds until the next load completes.
- stall_o = (IDLE & access & legal & aligned) | REQ | WAIT. It is 0 in DONE, so the pipeline advances exactly once per access and the access is never re-issued.
- Byte enables and store data:
  - Byte: be = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - Half: be = 0011 << addr[1:0], wdata = {2{wdata[15:0]}}.
  - Word: be = 1111, wdata = wdata_i.
- Load format:
  - Select the byte or half at addr[1:0] from bus_rdata_i.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Minimum latency from IDLE to DONE inclusive: store 3 cycles, load 4 cycles. Each extra cycle without gnt or rvalid adds one.
- flush_i in REQ or WAIT is ignored: an issued transaction always completes.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The state enum lsu_state_t {IDLE, REQ, WAIT, DONE}.
  - The misalignment helper function.
- One combinational sub-module, lsu_align: store lane replication, byte-enable generation and load extract/extend. It is reused by the future cache path.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, gnt the cycle after req → bus_addr=0x100, be=1111, wdata=0xDEADBEEF; stall high 2 cycles; DONE on cycle 3.
- LB addr=0x103, rdata=0x80FF_0000 with rvalid 3 cycles after gnt → ram_data_o=0xFFFFFF80; stall holds until rvalid.
- LHU addr=0x102, rdata=0x8001_1234 → 0x00008001. LH on the same data → 0xFFFF8001.
- SB addr=0x201 wdata=0x000000AB → be=0010, bus_wdata=0xABABABAB. SH addr=0x202 wdata=0x0000CAFE → be=1100.
- LW addr=0x102 → err_o=1, bus_req_o never asserts, stall_o=0. funct3=011 → err_o=1.
- rst_n low while in WAIT → bus_req_o=0 and stall_o=0 immediately. After release, a fresh LW completes normally. flush_i in IDLE → no request issued.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, controller state type and access-check helpers
// shared by the load/store unit and its alignment datapath.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    function automatic logic misaligned(
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        return (funct3[1:0] == 2'b01 && off[0]) ||
               (funct3[1:0] == 2'b10 && off != 2'b00);
    endfunction

    function automatic logic legal_f3(
        input logic [2:0] funct3,
        input logic       store
    );
        if (store)
            return funct3 inside {F3_B, F3_H, F3_W};
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication, byte-enable generation and
// load byte/half extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_fmt
);

    logic [31:0] shifted;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_fmt = rdata;
        shifted   = rdata >> {off, 3'b000};
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        case (funct3)
            F3_B:    rdata_fmt = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_fmt = {24'd0, shifted[7:0]};
            F3_H:    rdata_fmt = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_fmt = {16'd0, shifted[15:0]};
            default: rdata_fmt = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: issues loads/stores on a req/gnt/rvalid data bus, stalls the
// pipeline until the access completes and flags bad accesses.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_re_i,
    input  logic              mem_we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              flush_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              stall_o,
    output logic              err_o
);

    lsu_state_t  state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        idle;
    logic        access;
    logic        ok;
    logic        go;
    logic [2:0]  sel_f3;
    logic [1:0]  sel_off;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] rfmt;

    assign idle   = (state == IDLE);
    assign access = (mem_re_i | mem_we_i) & ~flush_i;
    assign ok     = legal_f3(funct3_i, mem_we_i) &
                    ~misaligned(funct3_i, addr_i[1:0]);
    assign go     = idle & access & ok;
    assign err_o  = idle & access & ~ok;
    assign stall_o = go | (state == REQ) | (state == WAIT);

    // Stores format from the live request; loads from the latched one.
    assign sel_f3  = idle ? funct3_i : f3_q;
    assign sel_off = idle ? addr_i[1:0] : off_q;

    lsu_align u_align (
        .funct3    (sel_f3),
        .off       (sel_off),
        .wdata     (wdata_i),
        .rdata     (bus_rdata_i),
        .be        (be),
        .wdata_rep (wrep),
        .rdata_fmt (rfmt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= 4'd0;
            bus_wdata_o <= '0;
            ram_data_o  <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    f3_q        <= funct3_i;
                    off_q       <= addr_i[1:0];
                    bus_req_o   <= 1'b1;
                    bus_we_o    <= mem_we_i;
                    bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                    bus_be_o    <= be;
                    bus_wdata_o <= wrep;
                    state       <= REQ;
                end
                REQ: if (bus_gnt_i) begin
                    bus_req_o <= 1'b0;
                    state     <= bus_we_o ? DONE : WAIT;
                end
                WAIT: if (bus_rvalid_i) begin
                    ram_data_o <= rfmt;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed table, randomized accesses against a byte-level
// reference model, and reset/flush corner sequences for lsu_ctrl.
module tb_lsu_ctrl;

    logic        clk = 0;
    logic        rst_n;
    logic        mem_re_i, mem_we_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic [31:0] ram_data_o;
    logic        stall_o, err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_re_i     (mem_re_i),
        .mem_we_i     (mem_we_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .flush_i      (flush_i),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .ram_data_o   (ram_data_o),
        .stall_o      (stall_o),
        .err_o        (err_o)
    );

    typedef struct {
        bit          err;
        bit          issued;
        bit          we;
        bit          hold_bad;
        bit          done_stall;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] bw;
        logic [31:0] ram;
        int          stall_cyc;
    } obs_t;

    typedef struct {
        bit          re;
        bit          we;
        bit          fl;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          g;
        int          r;
        bit          err;
        logic [3:0]  be;
        logic [31:0] bw;
        logic [31:0] ram;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic obs_t blank(input logic [31:0] prev);
        obs_t e;
        e.err = 0; e.issued = 0; e.we = 0; e.hold_bad = 0;
        e.done_stall = 0; e.addr = 0; e.be = 0; e.bw = 0;
        e.ram = prev; e.stall_cyc = 0;
        return e;
    endfunction

    // Reference: derive everything from access size and byte offset.
    function automatic obs_t model(input bit re, input bit we, input bit fl,
                                   input logic [2:0] f3,
                                   input logic [31:0] addr, wd, rd,
                                   input int g, input int r,
                                   input logic [31:0] prev);
        obs_t e;
        int unsigned size, off;
        logic [31:0] mask, v;
        bit ok;
        e = blank(prev);
        if (!(re || we) || fl) return e;
        ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = 1 << f3[1:0];
        if (!ok || (addr % size) != 0) begin
            e.err = 1;
            return e;
        end
        off = addr % 4;
        e.issued = 1;
        e.we = we;
        e.addr = addr - off;
        e.be = 4'(((1 << size) - 1) << off);
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 1;
        if (size == 1) e.bw = (wd & 32'hFF) * 32'h0101_0101;
        else if (size == 2) e.bw = (wd & 32'hFFFF) * 32'h0001_0001;
        else e.bw = wd;
        e.stall_cyc = we ? 2 + g : 3 + g + r;
        if (!we) begin
            v = (rd >> (8 * off)) & mask;
            if (!f3[2] && size < 4 && v > (mask >> 1)) v = v | ~mask;
            e.ram = v;
        end
        return e;
    endfunction

    task automatic run_access(input bit re, input bit we, input bit fl,
                              input logic [2:0] f3,
                              input logic [31:0] addr, wd, rd,
                              input int g, input int r,
                              input bit bad_rv, input bit busy_fl,
                              output obs_t o);
        o = blank(32'h0);
        mem_re_i = re; mem_we_i = we; flush_i = fl;
        funct3_i = f3; addr_i = addr; wdata_i = wd;
        #1;
        o.err = err_o;
        o.stall_cyc = int'(stall_o);
        if (!stall_o) begin
            step();
            o.issued = bus_req_o;
            o.ram = ram_data_o;
            mem_re_i = 0; mem_we_i = 0; flush_i = 0;
            return;
        end
        step();
        flush_i = busy_fl;
        o.issued = bus_req_o;
        o.we = bus_we_o;
        o.addr = bus_addr_o;
        o.be = bus_be_o;
        o.bw = bus_wdata_o;
        for (int i = 0; i < g; i++) begin
            bus_gnt_i = 0;
            #1;
            if (stall_o) o.stall_cyc++;
            if (!bus_req_o || bus_addr_o !== o.addr || bus_be_o !== o.be ||
                bus_wdata_o !== o.bw) o.hold_bad = 1;
            step();
        end
        bus_gnt_i = 1;
        if (!we && bad_rv) begin
            bus_rvalid_i = 1;
            bus_rdata_i = ~rd;
        end
        #1;
        if (stall_o) o.stall_cyc++;
        step();
        bus_gnt_i = 0;
        bus_rvalid_i = 0;
        if (!we) begin
            for (int i = 0; i < r; i++) begin
                #1;
                if (stall_o) o.stall_cyc++;
                if (bus_req_o) o.hold_bad = 1;
                step();
            end
            bus_rvalid_i = 1;
            bus_rdata_i = rd;
            #1;
            if (stall_o) o.stall_cyc++;
            step();
            bus_rvalid_i = 0;
            bus_rdata_i = $urandom;
        end
        #1;
        o.done_stall = stall_o;
        if (bus_req_o) o.hold_bad = 1;
        o.ram = ram_data_o;
        mem_re_i = 0; mem_we_i = 0; flush_i = 0;
        step();
    endtask

    task automatic compare(input string tag, input obs_t o, input obs_t e);
        chk({tag, ".err"}, 32'(o.err), 32'(e.err));
        chk({tag, ".issued"}, 32'(o.issued), 32'(e.issued));
        chk({tag, ".stall_cycles"}, o.stall_cyc, e.stall_cyc);
        chk({tag, ".ram_data"}, o.ram, e.ram);
        if (e.issued) begin
            chk({tag, ".bus_addr"}, o.addr, e.addr);
            chk({tag, ".bus_we"}, 32'(o.we), 32'(e.we));
            chk({tag, ".bus_be"}, 32'(o.be), 32'(e.be));
            if (e.we) chk({tag, ".bus_wdata"}, o.bw, e.bw);
            chk({tag, ".hold"}, 32'(o.hold_bad), 32'd0);
            chk({tag, ".done_stall"}, 32'(o.done_stall), 32'd0);
        end
    endtask

    vec_t tbl[13];
    obs_t o, e;
    logic [31:0] last_ram;

    initial begin
        tbl[0]  = '{0,1,0,3'b010,32'h100,32'hDEADBEEF,32'h0,0,0,0,4'hF,32'hDEADBEEF,32'h0};
        tbl[1]  = '{1,0,0,3'b000,32'h103,32'h0,32'h80FF0000,0,3,0,4'h8,32'h0,32'hFFFFFF80};
        tbl[2]  = '{1,0,0,3'b101,32'h102,32'h0,32'h80011234,0,0,0,4'hC,32'h0,32'h00008001};
        tbl[3]  = '{1,0,0,3'b001,32'h102,32'h0,32'h80011234,1,0,0,4'hC,32'h0,32'hFFFF8001};
        tbl[4]  = '{0,1,0,3'b000,32'h201,32'hAB,32'h0,0,0,0,4'h2,32'hABABABAB,32'hFFFF8001};
        tbl[5]  = '{0,1,0,3'b001,32'h202,32'hCAFE,32'h0,2,0,0,4'hC,32'hCAFECAFE,32'hFFFF8001};
        tbl[6]  = '{1,0,0,3'b010,32'h102,32'h0,32'h0,0,0,1,4'h0,32'h0,32'hFFFF8001};
        tbl[7]  = '{1,0,0,3'b011,32'h100,32'h0,32'h0,0,0,1,4'h0,32'h0,32'hFFFF8001};
        tbl[8]  = '{1,0,0,3'b100,32'h101,32'h0,32'h123480FF,0,0,0,4'h2,32'h0,32'h00000080};
        tbl[9]  = '{1,0,0,3'b010,32'h104,32'h0,32'hCAFEF00D,2,1,0,4'hF,32'h0,32'hCAFEF00D};
        tbl[10] = '{0,1,0,3'b100,32'h100,32'h1,32'h0,0,0,1,4'h0,32'h0,32'hCAFEF00D};
        tbl[11] = '{0,1,0,3'b001,32'h203,32'h1,32'h0,0,0,1,4'h0,32'h0,32'hCAFEF00D};
        tbl[12] = '{1,0,1,3'b010,32'h300,32'h0,32'h0,0,0,0,4'h0,32'h0,32'hCAFEF00D};

        rst_n = 0;
        mem_re_i = 0; mem_we_i = 0; flush_i = 0;
        funct3_i = 0; addr_i = 0; wdata_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
        step();
        step();
        chk("rst.bus_req", 32'(bus_req_o), 0);
        chk("rst.bus_we", 32'(bus_we_o), 0);
        chk("rst.bus_addr", bus_addr_o, 0);
        chk("rst.bus_be", 32'(bus_be_o), 0);
        chk("rst.bus_wdata", bus_wdata_o, 0);
        chk("rst.ram_data", ram_data_o, 0);
        chk("rst.stall", 32'(stall_o), 0);
        chk("rst.err", 32'(err_o), 0);
        rst_n = 1;
        step();

        for (int i = 0; i < 13; i++) begin
            e = blank(tbl[i].ram);
            e.err = tbl[i].err;
            e.issued = (tbl[i].re || tbl[i].we) && !tbl[i].fl && !tbl[i].err;
            if (e.issued) begin
                e.we = tbl[i].we;
                e.addr = tbl[i].addr & ~32'h3;
                e.be = tbl[i].be;
                e.bw = tbl[i].bw;
                e.stall_cyc = tbl[i].we ? 2 + tbl[i].g : 3 + tbl[i].g + tbl[i].r;
            end
            run_access(tbl[i].re, tbl[i].we, tbl[i].fl, tbl[i].f3, tbl[i].addr,
                       tbl[i].wd, tbl[i].rd, tbl[i].g, tbl[i].r, 1'b0, 1'b0, o);
            compare($sformatf("vec%0d", i), o, e);
        end
        last_ram = 32'hCAFEF00D;

        for (int n = 0; n < 200; n++) begin
            bit re, we, fl, brv, bfl;
            logic [2:0] f3;
            logic [31:0] addr, wd, rd;
            int g, r, kind;
            kind = $urandom_range(0, 15);
            re = (kind < 7);
            we = (kind >= 7 && kind < 14);
            fl = ($urandom_range(0, 9) == 0);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2))
                                                   : (($urandom_range(0, 1) == 1) ? 3'($urandom_range(4, 5))
                                                                                 : 3'($urandom_range(0, 2)));
            addr = $urandom;
            wd = $urandom;
            rd = $urandom;
            g = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            brv = $urandom_range(0, 1) == 1;
            bfl = $urandom_range(0, 1) == 1;
            e = model(re, we, fl, f3, addr, wd, rd, g, r, last_ram);
            run_access(re, we, fl, f3, addr, wd, rd, g, r, brv, bfl, o);
            compare($sformatf("rnd%0d", n), o, e);
            last_ram = e.ram;
        end

        // Reset while waiting for read data.
        mem_re_i = 1; funct3_i = 3'b010; addr_i = 32'h300;
        step();
        bus_gnt_i = 1;
        step();
        bus_gnt_i = 0;
        mem_re_i = 0;
        #1;
        chk("wait.stall_before_rst", 32'(stall_o), 1);
        rst_n = 0;
        #1;
        chk("wait_rst.bus_req", 32'(bus_req_o), 0);
        chk("wait_rst.stall", 32'(stall_o), 0);
        chk("wait_rst.ram_data", ram_data_o, 0);
        chk("wait_rst.bus_addr", bus_addr_o, 0);
        step();
        rst_n = 1;
        step();
        e = model(1, 0, 0, 3'b010, 32'h400, 0, 32'h13579BDF, 1, 2, 32'h0);
        run_access(1, 0, 0, 3'b010, 32'h400, 0, 32'h13579BDF, 1, 2, 1'b1, 1'b0, o);
        compare("after_rst", o, e);

        // Reset while the request is still outstanding.
        mem_we_i = 1; funct3_i = 3'b010; addr_i = 32'h500; wdata_i = 32'h1;
        step();
        mem_we_i = 0;
        #1;
        chk("req.bus_req_before_rst", 32'(bus_req_o), 1);
        rst_n = 0;
        #1;
        chk("req_rst.bus_req", 32'(bus_req_o), 0);
        chk("req_rst.stall", 32'(stall_o), 0);
        step();
        rst_n = 1;
        step();

        // Flushed load: nothing goes out over several cycles.
        mem_re_i = 1; flush_i = 1; funct3_i = 3'b010; addr_i = 32'h600;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("flush%0d.stall", i), 32'(stall_o), 0);
            step();
            chk($sformatf("flush%0d.bus_req", i), 32'(bus_req_o), 0);
        end
        mem_re_i = 0; flush_i = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
